// File: rtl/_bus32_pkg.sv
// Shared definitions for the 32-bit transceiver bus reader.
//   state_e : controller state encoding (IDLE, DRIVE, RESP)
//   BUS_W   : width of the shared data bus
//   CNT_W   : width of the settle counter (holds SETTLE-1, SETTLE <= 15)
package _bus32_pkg;

    localparam int BUS_W = 32;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage : _bus32_pkg

// File: rtl/_bus32_oe_dec.sv
// Output-enable decoder for the 74x245 source transceivers.
// Turns a registered source index plus a drive flag into an active-low
// one-hot enable vector. With the drive flag low every enable is high,
// so no source can reach the bus.
//   src_i   [SW-1:0] : registered source slot index
//   drive_i          : 1 while the controller is in its drive state
//   g_o     [N-1:0]  : per-slot active-low output enable
module _bus32_oe_dec #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [SW-1:0] src_i,
    input  logic          drive_i,
    output logic [N-1:0]  g_o
);

    always_comb begin
        g_o = '1;
        if (drive_i) begin
            for (int i = 0; i < N; i++) begin
                if (src_i == SW'(i)) begin
                    g_o[i] = 1'b0;
                end
            end
        end
    end

endmodule : _bus32_oe_dec

// File: rtl/_bus32_rd.sv
// Read controller at the receiving end of the shared 32-bit bus.
// Accepts a request naming a source slot, enables that slot's transceiver
// for SETTLE cycles, captures the bus on the last of them and returns the
// word on a valid/ready response channel. The drive and response phases
// never overlap, so at least two all-high enable cycles separate drives.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake, req_src selects the slot
//   g [N-1:0]            : active-low per-slot output enables
//   bus [31:0]           : shared bus value
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data, rsp_err    : captured word, out-of-range index flag
module _bus32_rd
    import _bus32_pkg::*;
#(
    parameter int N      = 8,
    parameter int SW     = (N <= 2) ? 1 : $clog2(N),
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SW-1:0]    req_src,
    output logic [N-1:0]     g,
    input  logic [BUS_W-1:0] bus,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BUS_W-1:0] rsp_data,
    output logic             rsp_err
);

    generate
        if (SETTLE < 1 || SETTLE > 15 || N < 2 || N > 16 || N > (1 << SW)) begin : g_bad_param
            $error("_bus32_rd: illegal parameter combination");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [SW-1:0]      src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_W-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               src_bad;

    assign src_bad = (32'(req_src) >= 32'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    if (src_bad) begin
                        // Out-of-range slot: answer at once, never enable anything.
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        src_d   = req_src;
                        cnt_d   = CNT_W'(SETTLE - 1);
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    data_d  = bus;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so that ready stays low during reset and rises on the
        // first edge after release.
        ready_d = (state_d == ST_IDLE);
    end

    // Enables are decoded from registers only, so reset clears them
    // asynchronously without waiting for an edge.
    _bus32_oe_dec #(
        .N  (N),
        .SW (SW)
    ) u_oe_dec (
        .src_i   (src_q),
        .drive_i (state_q == ST_DRIVE),
        .g_o     (g)
    );

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

    a_one_driver : assert property (@(posedge clk) $countones(~g) <= 1)
        else $error("_bus32_rd: more than one output enable active");

endmodule : _bus32_rd

// File: tb/tb__bus32_rd.sv
module tb__bus32_rd;

    logic        clk;
    logic        rst_n;

    // N=8, SETTLE=2 instance
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [2:0]  req_src;
    logic [7:0]  g;
    logic [31:0] bus, rsp_data;

    // N=6, SW=3, SETTLE=2 instance
    logic        req_valid6, req_ready6, rsp_valid6, rsp_ready6, rsp_err6;
    logic [2:0]  req_src6;
    logic [5:0]  g6;
    logic [31:0] bus6, rsp_data6;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    _bus32_rd #(.N(8), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
        .g(g), .bus(bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    _bus32_rd #(.N(6), .SW(3), .SETTLE(2)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_src(req_src6),
        .g(g6), .bus(bus6),
        .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready6),
        .rsp_data(rsp_data6), .rsp_err(rsp_err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_src = 3'($urandom); bus = $urandom; rsp_ready = 1'($urandom);
            req_valid6 = 1'($urandom); req_src6 = 3'($urandom); bus6 = $urandom; rsp_ready6 = 1'($urandom);
        end
        #1;
        chk_cnt++; if (g !== 8'hFF) $display("FAIL reset_g got %h want ff", g); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", req_ready); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else pass_cnt++;
        chk_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else pass_cnt++;
        chk_cnt++; if (g6 !== 6'h3F) $display("FAIL reset_g6 got %h want 3f", g6); else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b0; req_src = 3'd0; bus = 32'h0; rsp_ready = 1'b1;
        req_valid6 = 1'b0; req_src6 = 3'd0; bus6 = 32'h0; rsp_ready6 = 1'b1;
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_ready_before_edge got %b want 0", req_ready); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready_after_edge got %b want 1", req_ready); else pass_cnt++;
        chk_cnt++; if (req_ready6 !== 1'b1) $display("FAIL reset_ready6_after_edge got %b want 1", req_ready6); else pass_cnt++;
    endtask

    task automatic test_basic_read();
        req_valid = 1'b1; req_src = 3'd3; bus = 32'hDEADBEEF; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if (g !== 8'hF7) $display("FAIL basic_g_c1 got %h want f7", g); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL basic_ready_c1 got %b want 0", req_ready); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (g !== 8'hF7) $display("FAIL basic_g_c2 got %h want f7", g); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL basic_valid_c2 got %b want 0", rsp_valid); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (g !== 8'hFF) $display("FAIL basic_g_c3 got %h want ff", g); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL basic_valid_c3 got %b want 1", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL basic_data got %h want deadbeef", rsp_data); else pass_cnt++;
        chk_cnt++; if (rsp_err !== 1'b0) $display("FAIL basic_err got %b want 0", rsp_err); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL basic_valid_c4 got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (g !== 8'hFF) $display("FAIL basic_g_c4 got %h want ff", g); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL basic_ready_c4 got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        req_valid = 1'b1; req_src = 3'd3; bus = 32'hDEADBEEF; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++; if (n !== 3) $display("FAIL bp_latency got %0d want 3", n); else pass_cnt++;
        bus = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_%0d got %b want 1", i, rsp_valid); else pass_cnt++;
            chk_cnt++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL bp_data_%0d got %h want deadbeef", i, rsp_data); else pass_cnt++;
            chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready_%0d got %b want 0", i, req_ready); else pass_cnt++;
            chk_cnt++; if (g !== 8'hFF) $display("FAIL bp_g_%0d got %h want ff", i, g); else pass_cnt++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL bp_data_kept got %h want deadbeef", rsp_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_g [6];
        exp_g = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h7F, 8'h7F};
        req_valid = 1'b1; req_src = 3'd0; rsp_ready = 1'b1; bus = 32'h1111_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_cnt++; if (g !== exp_g[i]) $display("FAIL b2b_g_%0d got %h want %h", i, g, exp_g[i]); else pass_cnt++;
            chk_cnt++; if ($countones(~g) > 1) $display("FAIL b2b_onehot_%0d got %h want at most one low", i, g); else pass_cnt++;
            if (i == 0) req_src = 3'd7;
            if (i == 4) req_valid = 1'b0;
        end
        @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL b2b_rsp_valid got %b want 1", rsp_valid); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_idle got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_invalid_index();
        req_valid6 = 1'b1; req_src6 = 3'd6; rsp_ready6 = 1'b0; bus6 = 32'hCAFEF00D;
        chk_cnt++; if (req_ready6 !== 1'b1) $display("FAIL inv_ready got %b want 1", req_ready6); else pass_cnt++;
        @(negedge clk);
        req_valid6 = 1'b0;
        chk_cnt++; if (rsp_valid6 !== 1'b1) $display("FAIL inv_valid got %b want 1", rsp_valid6); else pass_cnt++;
        chk_cnt++; if (rsp_err6 !== 1'b1) $display("FAIL inv_err got %b want 1", rsp_err6); else pass_cnt++;
        chk_cnt++; if (rsp_data6 !== 32'h0) $display("FAIL inv_data got %h want 0", rsp_data6); else pass_cnt++;
        chk_cnt++; if (g6 !== 6'h3F) $display("FAIL inv_g_c1 got %h want 3f", g6); else pass_cnt++;
        rsp_ready6 = 1'b1;
        @(negedge clk);
        chk_cnt++; if (rsp_valid6 !== 1'b0) $display("FAIL inv_valid_done got %b want 0", rsp_valid6); else pass_cnt++;
        chk_cnt++; if (g6 !== 6'h3F) $display("FAIL inv_g_c2 got %h want 3f", g6); else pass_cnt++;
        // Highest legal slot of the N=6 instance still works and clears the error.
        req_valid6 = 1'b1; req_src6 = 3'd5; bus6 = 32'h1234_5678;
        @(negedge clk);
        req_valid6 = 1'b0;
        chk_cnt++; if (g6 !== 6'h1F) $display("FAIL inv_ok_g got %h want 1f", g6); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++; if (rsp_valid6 !== 1'b1) $display("FAIL inv_ok_valid got %b want 1", rsp_valid6); else pass_cnt++;
        chk_cnt++; if (rsp_err6 !== 1'b0) $display("FAIL inv_ok_err got %b want 0", rsp_err6); else pass_cnt++;
        chk_cnt++; if (rsp_data6 !== 32'h1234_5678) $display("FAIL inv_ok_data got %h want 12345678", rsp_data6); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drive();
        req_valid = 1'b1; req_src = 3'd5; bus = 32'hAAAA5555; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if (g !== 8'hDF) $display("FAIL mid_g_c1 got %h want df", g); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (g !== 8'hDF) $display("FAIL mid_g_c2 got %h want df", g); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++; if (g !== 8'hFF) $display("FAIL mid_g_async got %h want ff", g); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid_async got %b want 0", rsp_valid); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid_held got %b want 0", rsp_valid); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid_after got %b want 0", rsp_valid); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL mid_ready_after got %b want 1", req_ready); else pass_cnt++;
        req_valid = 1'b1; req_src = 3'd2; bus = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if (g !== 8'hFB) $display("FAIL mid_new_g1 got %h want fb", g); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (g !== 8'hFB) $display("FAIL mid_new_g2 got %h want fb", g); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL mid_new_valid got %b want 1", rsp_valid); else pass_cnt++;
        chk_cnt++; if (rsp_data !== 32'h0BAD_F00D) $display("FAIL mid_new_data got %h want 0badf00d", rsp_data); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_src = 3'd0; bus = 32'h0; rsp_ready = 1'b0;
        req_valid6 = 1'b0; req_src6 = 3'd0; bus6 = 32'h0; rsp_ready6 = 1'b0;
        test_reset();
        test_basic_read();
        test_backpressure();
        test_back_to_back();
        test_invalid_index();
        test_reset_mid_drive();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb__bus32_rd
